// File: rtl/udm_cpu_mem_arbiter.sv
// Round-robin N:1 memory bus arbiter with stall lock and in-order read ID FIFO.
// Optional read-response watchdog: define MEMARB_TIMEOUT_EN.
module udm_cpu_mem_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [32*NUM_MASTERS-1:0] m_addr_i,
  input  logic [4*NUM_MASTERS-1:0]  m_be_i,
  input  logic [32*NUM_MASTERS-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]    m_resp_o,
  output logic [31:0]               m_rdata_o,
  output logic                      s_req_o,
  input  logic                      s_ack_i,
  output logic                      s_we_o,
  output logic [31:0]               s_addr_o,
  output logic [3:0]                s_be_o,
  output logic [31:0]               s_wdata_o,
`ifdef MEMARB_TIMEOUT_EN
  output logic                      to_err_o,
`endif
  input  logic                      s_resp_i,
  input  logic [31:0]               s_rdata_i
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int AW = $clog2(MAX_OUTSTANDING);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_sel;
  logic [IW-1:0] sel;
  logic [IW-1:0] locked_id;
  logic          lock;

  logic [IW-1:0] id_mem [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [IW-1:0] head;
  logic          empty;
  logic          full;
  logic          pop;
  logic          fwd_pop;
  logic          push;
  logic          accept;
  logic          block;

  always_comb begin
    int  idx;
    logic found;
    rr_sel = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_MASTERS;
      if (!found && m_req_i[idx]) begin
        rr_sel = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign sel   = lock ? locked_id : rr_sel;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(MAX_OUTSTANDING));
  assign head  = id_mem[rd_ptr];

  // A response freeing a slot this cycle lets a read through a full FIFO.
  assign block  = ~m_we_i[sel] & full & ~pop;
  assign s_req_o = m_req_i[sel] & ~block;
  assign accept = s_req_o & s_ack_i;
  assign push   = accept & ~m_we_i[sel];

  assign s_we_o    = m_we_i[sel];
  assign s_addr_o  = m_addr_i[32*sel +: 32];
  assign s_be_o    = m_be_i[4*sel +: 4];
  assign s_wdata_o = m_wdata_i[32*sel +: 32];

  always_comb begin
    m_ack_o = '0;
    if (accept) m_ack_o[sel] = 1'b1;
  end

  always_comb begin
    m_resp_o = '0;
    if (pop) m_resp_o[head] = 1'b1;
  end

`ifdef MEMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic [3:0]    skip_cnt;
  logic          skip_resp;
  logic          tmo_fire;

  // Responses owed to already-timed-out reads are swallowed.
  assign skip_resp = s_resp_i & (skip_cnt != 4'd0);
  assign fwd_pop   = s_resp_i & ~skip_resp & ~empty;
  assign tmo_fire  = ~empty & ~fwd_pop &
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign pop       = fwd_pop | tmo_fire;
  assign m_rdata_o = tmo_fire ? 32'hDEAD_BEEF : s_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt  <= '0;
      skip_cnt <= '0;
      to_err_o <= 1'b0;
    end else begin
      if (pop || empty) tmo_cnt <= '0;
      else              tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_fire && !skip_resp) begin
        if (skip_cnt != 4'hf) skip_cnt <= skip_cnt + 4'd1;
      end else if (skip_resp && !tmo_fire) begin
        skip_cnt <= skip_cnt - 4'd1;
      end
      if (tmo_fire) to_err_o <= 1'b1;
    end
  end
`else
  assign fwd_pop   = s_resp_i & ~empty;
  assign pop       = fwd_pop;
  assign m_rdata_o = s_rdata_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr    <= IW'(NUM_MASTERS - 1);
      lock      <= 1'b0;
      locked_id <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (s_req_o && !s_ack_i) begin
        lock      <= 1'b1;
        locked_id <= sel;
      end else begin
        lock      <= 1'b0;
      end
      if (accept) rr_ptr <= sel;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

endmodule

// File: doc/udm_cpu_mem_arbiter.md
Name: udm_cpu_mem_arbiter

Overview:
- N-master to 1-slave arbiter for the shared on-chip memory bus.
- Lets the CPU data port and the UART debug master (UDM) share one memory/IO port in the memsplit SoC.
- Round-robin arbitration with grant lock during slave stall; pipelined reads are tracked through an in-order ID FIFO.
- Bus protocol: req/ack per transfer, writes unacknowledged beyond ack, reads return one resp pulse each, in order.

Parameters:
- NUM_MASTERS, 2, number of requesters (1..4); master 0 = CPU, master 1 = UDM.
- MAX_OUTSTANDING, 4, read ID FIFO depth, power of 2, 2..16.
- TIMEOUT_CYCLES, 1023, read response watchdog limit (used only with MEMARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- m_req_i  in  NUM_MASTERS  per-master request
- m_ack_o  out  NUM_MASTERS  per-master accept
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_addr_i  in  32*NUM_MASTERS  packed addresses, master k at [32k+31:32k]
- m_be_i  in  4*NUM_MASTERS  packed byte enables
- m_wdata_i  in  32*NUM_MASTERS  packed write data
- m_resp_o  out  NUM_MASTERS  per-master read response strobe
- m_rdata_o  out  32  read data, shared, valid with m_resp_o
- s_req_o  out  1  slave request
- s_ack_i  in  1  slave accept
- s_we_o / s_addr_o / s_be_o / s_wdata_o  out  1/32/4/32  muxed from selected master
- s_resp_i  in  1  slave read response
- s_rdata_i  in  32  slave read data

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values:
  - rr_ptr = NUM_MASTERS-1, so master 0 wins first.
  - lock = 0, FIFO empty, all m_ack_o/m_resp_o = 0, s_req_o = 0.
- Selection, when lock = 0:
  - First requesting master scanning from rr_ptr+1 upward, with wrap-around.
  - Combinational, same cycle as the request.
- Lock:
  - lock = 1 and locked_id registered when s_req_o = 1 and s_ack_i = 0.
  - While locked, selection is forced to locked_id, so the slave sees stable addr/data during a stall.
  - lock clears on the accepting cycle.
- Forwarding:
  - s_req_o = m_req_i[sel] & ~block.
  - m_ack_o[sel] = s_ack_i & s_req_o; all other acks are 0.
  - Zero added latency on request and ack paths.
- Block:
  - block = ~m_we_i[sel] & fifo_full.
  - A write is never blocked; a read waits until a slot frees.
- Accept (s_req_o & s_ack_i):
  - rr_ptr <= sel.
  - If read, push sel into the ID FIFO.
- Response:
  - On s_resp_i, pop the FIFO head; m_resp_o[head] = 1 in the same cycle.
  - m_rdata_o = s_rdata_i, broadcast; masters qualify with their own resp bit.
- Simultaneous push and pop: allowed in one cycle, count unchanged; a full FIFO with a pop in the same cycle accepts the new read.
- s_resp_i with an empty FIFO: dropped, no m_resp_o.
- A master deasserting req before ack while locked: lock clears next cycle, and normal RR arbitration resumes.
- Reset mid-transfer: FIFO flushed; late slave responses after reset are dropped by the empty-FIFO rule.
- NUM_MASTERS = 1: pure pass-through plus the ID FIFO.

Optional Feature:
- Macro: MEMARB_TIMEOUT_EN.
- When defined:
  - A counter runs while the FIFO is non-empty and resets on each pop.
  - On reaching TIMEOUT_CYCLES: pulse m_resp_o[head] with m_rdata_o = 32'hDEADBEEF, pop the head, increment skip_cnt (4 bits, saturating).
  - While skip_cnt > 0, each s_resp_i decrements skip_cnt and is not forwarded.
  - Extra output to_err_o (1 bit): sticky, reset 0, set on any timeout.
- When undefined: no counter, no to_err_o port; a hung slave stalls the requesting master indefinitely.

Test Plan:
- Both masters issue reads every cycle, slave acks every cycle -> grants alternate 0,1,0,1; resp strobes follow issue order.
- CPU write at 0x100 while slave holds s_ack_i low for 3 cycles, UDM requests from cycle 1 -> s_addr_o stays 0x100 all 4 cycles; UDM granted on the cycle after the CPU ack.
- 4 reads accepted, no resp (MAX_OUTSTANDING = 4) -> 5th read s_req_o = 0; a write from the other master is still accepted; one s_resp_i releases the read in the same cycle.
- Push and pop in the same cycle with FIFO full -> no overflow; resp order matches issue order (ids 0,1,1,0,...).
- Spurious s_resp_i after reset -> no m_resp_o pulse; rst_i asserted with 2 reads outstanding -> FIFO empty next cycle.
- MEMARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8, slave never responds to a UDM read:
  - m_resp_o[1] = 1 with rdata 0xDEADBEEF at cycle 8; to_err_o = 1.
  - A later s_resp_i is swallowed.
